// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI master.
// Optional frame-2 header check is enabled with A2D_CHK_EN.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FRAME1,
    GAP,
    FRAME2,
    DONE
  } a2d_state_t;

  localparam int FRAME_BITS = 16;
  localparam int A2D_RES_W  = 12;
  localparam int CHNNL_LSB  = 11;

  function automatic logic [FRAME_BITS-1:0] cmd_word(
    input logic [2:0] ch
  );
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[CHNNL_LSB +: 3] = ch;
    return w;
  endfunction

endpackage

// File: rtl/a2d_intf_if.sv
// Request/result and SPI pin bundle for a2d_intf.
// a2d_err exists only when A2D_CHK_EN is defined.
interface a2d_intf_if;
  import a2d_pkg::*;

  logic                 strt_cnv;
  logic [2:0]           chnnl;
  logic                 cnv_cmplt;
  logic [A2D_RES_W-1:0] A2D_res;
  logic                 SS_n;
  logic                 SCLK;
  logic                 MOSI;
  logic                 MISO;
`ifdef A2D_CHK_EN
  logic                 a2d_err;
`endif

  modport master (
`ifdef A2D_CHK_EN
    output a2d_err,
`endif
    input  strt_cnv,
    input  chnnl,
    input  MISO,
    output cnv_cmplt,
    output A2D_res,
    output SS_n,
    output SCLK,
    output MOSI
  );

  modport slave (
`ifdef A2D_CHK_EN
    input  a2d_err,
`endif
    output strt_cnv,
    output chnnl,
    output MISO,
    input  cnv_cmplt,
    input  A2D_res,
    input  SS_n,
    input  SCLK,
    input  MOSI
  );

endinterface

// File: rtl/spi_shift16.sv
// One 16-bit SPI frame engine: SCLK divider, bit counter,
// tx/rx shift registers and an end-of-frame pulse.
module spi_shift16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_active,
  input  logic [FRAME_BITS-1:0] i_tx,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic [FRAME_BITS-1:0] o_rx,
  output logic                  o_frame_done
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] HALF = DW'(SCLK_DIV / 2);
  localparam logic [DW-1:0] SMPL = DW'(SCLK_DIV / 2 + 1);
  localparam logic [DW-1:0] LAST = DW'(SCLK_DIV - 1);

  logic [DW-1:0]         r_div;
  logic [3:0]            r_bit;
  logic [FRAME_BITS-1:0] r_tx;
  logic [FRAME_BITS-1:0] r_rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_bit <= '0;
      r_tx  <= '0;
      r_rx  <= '0;
    end else if (i_load) begin
      r_div <= '0;
      r_bit <= '0;
      r_tx  <= i_tx;
    end else if (i_active) begin
      r_div <= r_div + DW'(1);
      if (r_div == SMPL)
        r_rx <= {r_rx[FRAME_BITS-2:0], i_miso};
      if (r_div == LAST) begin
        r_tx  <= {r_tx[FRAME_BITS-2:0], 1'b0};
        r_bit <= r_bit + 4'd1;
      end
    end
  end

  // SCLK parks high outside a frame; low half of each bit comes first
  assign o_sclk       = i_active ? (r_div >= HALF) : 1'b1;
  assign o_mosi       = r_tx[FRAME_BITS-1];
  assign o_rx         = r_rx;
  assign o_frame_done = i_active && (r_div == LAST) && (r_bit == 4'd15);

endmodule

// File: rtl/a2d_intf.sv
// SPI master for the 8-channel 12-bit A2D: two frames per conversion.
// Define A2D_CHK_EN to add the sticky a2d_err header check.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input logic       clk,
  input logic       rst,
  a2d_intf_if.master bus
);

  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

  a2d_state_t            r_state;
  a2d_state_t            w_nxt;
  logic [2:0]            r_chnnl;
  logic [GW-1:0]         r_gap;
  logic                  r_cmplt;
  logic [A2D_RES_W-1:0]  r_res;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_active;
  logic                  w_done;
  logic [FRAME_BITS-1:0] w_tx;
  logic [FRAME_BITS-1:0] w_rx;
  logic                  w_sclk;
  logic                  w_mosi;

  always_comb begin
    w_nxt    = r_state;
    w_load   = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.strt_cnv) begin
          w_accept = 1'b1;
          w_load   = 1'b1;
          w_nxt    = FRAME1;
        end
      end
      FRAME1: if (w_done) w_nxt = GAP;
      GAP: begin
        if (r_gap == GAP_LAST) begin
          w_load = 1'b1;
          w_nxt  = FRAME2;
        end
      end
      FRAME2: if (w_done) w_nxt = DONE;
      DONE:   w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  assign w_active = (r_state == FRAME1) || (r_state == FRAME2);
  assign w_tx     = cmd_word(w_accept ? bus.chnnl : r_chnnl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_chnnl <= '0;
      r_gap   <= '0;
      r_cmplt <= 1'b0;
      r_res   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept)
        r_chnnl <= bus.chnnl;
      r_gap   <= (r_state == GAP) ? r_gap + GW'(1) : '0;
      r_cmplt <= (r_state == DONE);
      // frame-1 data belongs to the previous channel and is dropped
      if (r_state == DONE)
        r_res <= w_rx[A2D_RES_W-1:0];
    end
  end

  spi_shift16 #(
    .SCLK_DIV (SCLK_DIV)
  ) u_shift (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_active     (w_active),
    .i_tx         (w_tx),
    .i_miso       (bus.MISO),
    .o_sclk       (w_sclk),
    .o_mosi       (w_mosi),
    .o_rx         (w_rx),
    .o_frame_done (w_done)
  );

`ifdef A2D_CHK_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= 1'b0;
    else if (r_state == DONE && w_rx[FRAME_BITS-1:A2D_RES_W] != 4'h0)
      r_err <= 1'b1;
  end

  assign bus.a2d_err = r_err;
`else
  logic w_unused_hdr;
  assign w_unused_hdr = ^w_rx[FRAME_BITS-1:A2D_RES_W];
`endif

  assign bus.SS_n      = ~w_active;
  assign bus.SCLK      = w_sclk;
  assign bus.MOSI      = w_mosi;
  assign bus.cnv_cmplt = r_cmplt;
  assign bus.A2D_res   = r_res;

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf with a behavioural A2D model.
// Build with A2D_CHK_EN defined to also check a2d_err.
module tb_a2d_intf;
  import a2d_pkg::*;

  localparam int DIV = 32;
  localparam int GAP_N = 32;
  localparam int LAT = 32 * DIV + GAP_N + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  a2d_intf_if bus();

  a2d_intf #(
    .SCLK_DIV (DIV),
    .GAP_CLKS (GAP_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] res;
    logic        err;
    int          edge_at;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          edges = 0;
  int          n_cmplt = 0;
  logic [15:0] f2_word = 16'h0000;
  logic [2:0]  exp_ch = 3'd0;

  always @(posedge clk) edges++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // result monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.cnv_cmplt) begin
      n_cmplt++;
      if (sb.size() == 0) begin
        chk("spurious_cmplt", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("A2D_res", 32'(bus.A2D_res), 32'(e.res));
        chk("latency", edges - e.edge_at, LAT);
`ifdef A2D_CHK_EN
        chk("a2d_err", 32'(bus.a2d_err), 32'(e.err));
`endif
      end
    end
  end

  // A2D model plus SPI timing observer
  logic        p_ss = 1'b1;
  logic        p_sclk = 1'b1;
  int          fidx = 0;
  int          rises = 0;
  int          idx = 0;
  int          last_rise = 0;
  int          per_bad = 0;
  int          idle_bad = 0;
  int          ss_rise_edge = 0;
  logic [15:0] mosi_w = 16'h0;
  logic [15:0] miso_w = 16'h0;

  always @(negedge clk) begin
    if (rst) begin
      fidx = 0;
      bus.MISO = 1'b0;
      p_ss = 1'b1;
      p_sclk = 1'b1;
    end else begin
      if (bus.SS_n && !bus.SCLK) idle_bad++;
      if (p_ss && !bus.SS_n) begin
        fidx++;
        rises = 0;
        idx = 0;
        per_bad = 0;
        mosi_w = 16'h0;
        miso_w = (fidx == 2) ? f2_word : 16'hF5A5;
        bus.MISO = miso_w[15];
        chk("sclk_low_first", 32'(bus.SCLK), 32'd0);
        if (fidx == 2) chk("gap_len", edges - ss_rise_edge, GAP_N);
      end else if (!bus.SS_n && p_sclk && !bus.SCLK) begin
        idx++;
        bus.MISO = miso_w[15-idx];
      end
      if (!bus.SS_n && !p_sclk && bus.SCLK) begin
        if (rises > 0 && edges - last_rise != DIV) per_bad++;
        rises++;
        last_rise = edges;
        mosi_w = {mosi_w[14:0], bus.MOSI};
      end
      if (!p_ss && bus.SS_n) begin
        ss_rise_edge = edges;
        chk("sclk_rises", rises, 16);
        chk("sclk_period", per_bad, 0);
        chk("mosi_word", 32'(mosi_w), 32'(cmd_word(exp_ch)));
      end
      if (bus.cnv_cmplt) fidx = 0;
      p_ss = bus.SS_n;
      p_sclk = bus.SCLK;
    end
  end

  // called just after a negedge; strt_cnv is seen by the next posedge
  task automatic request(input logic [2:0] ch, input logic [15:0] w,
                         input logic err, input bit push);
    bus.chnnl = ch;
    bus.strt_cnv = 1'b1;
    exp_ch = ch;
    f2_word = w;
    if (push) sb.push_back('{w[11:0], err, edges + 1});
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    bus.chnnl = ~ch;
  endtask

  task automatic wait_cmplt();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 100; i++) begin
      @(negedge clk);
      if (bus.cnv_cmplt) begin
        seen = 1'b1;
        break;
      end
    end
    chk("cmplt_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.strt_cnv = 1'b0;
    bus.chnnl = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_SS_n", 32'(bus.SS_n), 32'd1);
    chk("rst_SCLK", 32'(bus.SCLK), 32'd1);
    chk("rst_MOSI", 32'(bus.MOSI), 32'd0);
    chk("rst_cmplt", 32'(bus.cnv_cmplt), 32'd0);
    chk("rst_res", 32'(bus.A2D_res), 32'd0);
`ifdef A2D_CHK_EN
    chk("rst_err", 32'(bus.a2d_err), 32'd0);
`endif

    // basic read
    request(3'd5, 16'h0C35, 1'b0, 1'b1);
    wait_cmplt();
    repeat (4) @(negedge clk);

    // request during a transaction is ignored
    request(3'd6, 16'h0777, 1'b0, 1'b1);
    repeat (298) @(negedge clk);
    bus.chnnl = 3'd2;
    bus.strt_cnv = 1'b1;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    wait_cmplt();
    repeat (LAT + 20) @(negedge clk);

    // reset during frame 2, while MOSI carries chnnl[2]=1
    request(3'd7, 16'h0ABC, 1'b0, 1'b0);
    repeat (620) @(negedge clk);
    chk("pre_rst_SS_n", 32'(bus.SS_n), 32'd0);
    chk("pre_rst_MOSI", 32'(bus.MOSI), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_SS_n", 32'(bus.SS_n), 32'd1);
    chk("abort_SCLK", 32'(bus.SCLK), 32'd1);
    chk("abort_MOSI", 32'(bus.MOSI), 32'd0);
    chk("abort_res", 32'(bus.A2D_res), 32'd0);
    chk("abort_cmplt", 32'(bus.cnv_cmplt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 20) @(negedge clk);
    request(3'd2, 16'h0321, 1'b0, 1'b1);
    wait_cmplt();
    repeat (4) @(negedge clk);

    // back-to-back
    request(3'd1, 16'h0001, 1'b0, 1'b1);
    wait_cmplt();
    request(3'd7, 16'h0FFF, 1'b0, 1'b1);
    wait_cmplt();
    repeat (4) @(negedge clk);

    // nonzero frame-2 header, then a clean request
    request(3'd3, 16'hA123, 1'b1, 1'b1);
    wait_cmplt();
    repeat (4) @(negedge clk);
    request(3'd6, 16'h0456, 1'b0, 1'b1);
`ifdef A2D_CHK_EN
    chk("err_cleared", 32'(bus.a2d_err), 32'd0);
`endif
    wait_cmplt();
    repeat (4) @(negedge clk);
`ifdef A2D_CHK_EN
    chk("err_stays_0", 32'(bus.a2d_err), 32'd0);
`endif

    chk("sb_empty", sb.size(), 0);
    chk("cmplt_count", n_cmplt, 7);
    chk("sclk_idle_high", idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
